// File: rtl/brick_sort_frame_packer_if.sv
// Stream-in / frame-out handshake bundle for the brick sort loader.
// slave: s_data/s_valid/s_last/m_ready in, s_ready/m_data/m_count/m_valid out.
interface brick_sort_frame_packer_if #(
  parameter int LOG_INPUT_NUM = 4,
  parameter int DATA_WIDTH    = 8
);
  localparam int INPUT_NUM = 2 ** LOG_INPUT_NUM;

  logic [DATA_WIDTH-1:0]           s_data;
  logic                            s_valid;
  logic                            s_last;
  logic                            s_ready;
  logic [INPUT_NUM*DATA_WIDTH-1:0] m_data;
  logic [LOG_INPUT_NUM:0]          m_count;
  logic                            m_valid;
  logic                            m_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    output m_ready,
    input  s_ready,
    input  m_data,
    input  m_count,
    input  m_valid
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    input  m_ready,
    output s_ready,
    output m_data,
    output m_count,
    output m_valid
  );
endinterface

// File: rtl/brick_sort_frame_packer.sv
// Packs a serial element stream into one padded frame for the sort network.
// Ports: clk, rst (sync, active-high), bus (slave view of the handshake bundle).
module brick_sort_frame_packer #(
  parameter int LOG_INPUT_NUM = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int ASCENDING     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  brick_sort_frame_packer_if.slave     bus
);
  localparam int INPUT_NUM = 2 ** LOG_INPUT_NUM;

  // Pad sorts to the tail so it lands in the top lanes.
  localparam logic [DATA_WIDTH-1:0] PAD =
    (ASCENDING != 0) ? '1 : '0;

  localparam logic [LOG_INPUT_NUM-1:0] IDX_ONE =
    LOG_INPUT_NUM'(1);
  localparam logic [LOG_INPUT_NUM-1:0] IDX_MAX =
    LOG_INPUT_NUM'(INPUT_NUM - 1);
  localparam logic [LOG_INPUT_NUM:0] CNT_ONE =
    (LOG_INPUT_NUM + 1)'(1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                   state;
  logic [LOG_INPUT_NUM-1:0] idx;
  logic [DATA_WIDTH-1:0]    lane [INPUT_NUM];
  logic [LOG_INPUT_NUM:0]   m_count_q;
  logic                     m_valid_q;
  logic                     s_ready_c;
  logic                     accept;
  logic                     close;

  assign s_ready_c = (state == FILL) && !rst;
  assign accept    = bus.s_valid && s_ready_c;
  assign close     = bus.s_last || (idx == IDX_MAX);

  assign bus.s_ready = s_ready_c;
  assign bus.m_count = m_count_q;
  assign bus.m_valid = m_valid_q;

  for (genvar g = 0; g < INPUT_NUM; g++) begin : g_lane
    assign bus.m_data[g*DATA_WIDTH +: DATA_WIDTH] = lane[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      m_valid_q <= 1'b0;
      m_count_q <= '0;
      for (int i = 0; i < INPUT_NUM; i++) begin
        lane[i] <= PAD;
      end
    end else begin
      unique case (1'b1)
        (state == FILL): begin
          if (accept) begin
            lane[idx] <= bus.s_data;
            if (close) begin
              m_count_q <= {1'b0, idx} + CNT_ONE;
              m_valid_q <= 1'b1;
              state     <= HOLD;
              idx       <= '0;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end
        (state == HOLD): begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            m_count_q <= '0;
            state     <= FILL;
            for (int i = 0; i < INPUT_NUM; i++) begin
              lane[i] <= PAD;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_brick_sort_frame_packer.sv
// Bench for brick_sort_frame_packer: two DUTs (ASCENDING 1 and 0) on one stream.
// Queue-based frame model checked each cycle, plus literal frame checks.
module tb_brick_sort_frame_packer;
  localparam int LOG = 2;
  localparam int N   = 4;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic s_valid = 1'b0;
  logic s_last  = 1'b0;
  logic m_ready = 1'b0;
  logic chk_en  = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  brick_sort_frame_packer_if #(.LOG_INPUT_NUM(LOG), .DATA_WIDTH(DW)) bus1 ();
  brick_sort_frame_packer_if #(.LOG_INPUT_NUM(LOG), .DATA_WIDTH(DW)) bus0 ();

  assign bus1.s_data  = s_data;
  assign bus1.s_valid = s_valid;
  assign bus1.s_last  = s_last;
  assign bus1.m_ready = m_ready;
  assign bus0.s_data  = s_data;
  assign bus0.s_valid = s_valid;
  assign bus0.s_last  = s_last;
  assign bus0.m_ready = m_ready;

  brick_sort_frame_packer #(
    .LOG_INPUT_NUM(LOG), .DATA_WIDTH(DW), .ASCENDING(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  brick_sort_frame_packer #(
    .LOG_INPUT_NUM(LOG), .DATA_WIDTH(DW), .ASCENDING(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Model: elements collected so far in the current frame, and
  // whether the frame is closed and waiting for the consumer.
  logic [DW-1:0] q[$];
  bit hold = 1'b0;

  function automatic logic [31:0] frame(input logic [DW-1:0] pad);
    logic [31:0] f;
    for (int i = 0; i < N; i++) begin
      f[i*DW +: DW] = (i < q.size()) ? q[i] : pad;
    end
    return f;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      hold = 1'b0;
    end else if (hold) begin
      if (m_ready) begin
        q.delete();
        hold = 1'b0;
      end
    end else if (s_valid) begin
      q.push_back(s_data);
      if (s_last || q.size() == N) hold = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("s_ready1", bus1.s_ready, !hold && !rst);
      check("s_ready0", bus0.s_ready, !hold && !rst);
      check("m_valid1", bus1.m_valid, hold);
      check("m_valid0", bus0.m_valid, hold);
      check("m_count1", bus1.m_count, hold ? q.size() : 0);
      check("m_count0", bus0.m_count, hold ? q.size() : 0);
      check("m_data1", bus1.m_data, frame(8'hFF));
      check("m_data0", bus0.m_data, frame(8'h00));
    end
  end

  // Frames taken by the consumer, for the split-frame test.
  logic [31:0] cap_d[$];
  logic [2:0]  cap_c[$];
  always @(negedge clk) begin
    if (bus1.m_valid && m_ready && !rst) begin
      cap_d.push_back(bus1.m_data);
      cap_c.push_back(bus1.m_count);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] saved;
    int k;
    int low;
    bit sr;

    step();
    step();
    chk_en = 1'b1;
    rst = 1'b0;
    #1;
    check("rst_mvalid", bus1.m_valid, 0);
    check("rst_count", bus1.m_count, 0);
    check("rst_data1", bus1.m_data, 32'hFFFFFFFF);
    check("rst_data0", bus0.m_data, 32'h00000000);
    check("rst_sready", bus1.s_ready, 1);

    // Full frame, held until the consumer takes it.
    push(8'h11, 0);
    push(8'h22, 0);
    push(8'h33, 0);
    check("full_early", bus1.m_valid, 0);
    push(8'h44, 0);
    check("full_valid", bus1.m_valid, 1);
    check("full_data", bus1.m_data, 32'h44332211);
    check("full_count", bus1.m_count, 4);
    check("full_sready", bus1.s_ready, 0);
    step();
    step();
    check("full_hold", bus1.m_data, 32'h44332211);
    handshake();
    check("hs_valid", bus1.m_valid, 0);
    check("hs_sready", bus1.s_ready, 1);

    // Short frame, both pad polarities.
    push(8'h05, 0);
    push(8'h09, 1);
    check("short_d1", bus1.m_data, 32'hFFFF0905);
    check("short_d0", bus0.m_data, 32'h00000905);
    check("short_cnt", bus1.m_count, 2);
    handshake();

    // Single element, then a fresh frame with no stale lanes.
    push(8'h07, 1);
    check("one_data", bus1.m_data, 32'hFFFFFF07);
    check("one_count", bus1.m_count, 1);
    handshake();
    push(8'h01, 0);
    push(8'h02, 0);
    push(8'h03, 1);
    check("three_data", bus1.m_data, 32'hFF030201);
    check("three_count", bus1.m_count, 3);
    handshake();

    // Over-long frame with s_valid and m_ready held high.
    cap_d.delete();
    cap_c.delete();
    m_ready = 1'b1;
    k = 0;
    low = 0;
    s_valid = 1'b1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      s_data = 8'hA0 + 8'(k);
      s_last = (k == 5);
      @(negedge clk);
      sr = bus1.s_ready;
      if (!sr) low++;
      step();
      if (sr) k++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
    step();
    m_ready = 1'b0;
    check("split_accepts", k, 6);
    check("split_gap", low, 1);
    check("split_frames", cap_d.size(), 2);
    if (cap_d.size() >= 2) begin
      check("split_d0", cap_d[0], 32'hA3A2A1A0);
      check("split_c0", cap_c[0], 4);
      check("split_d1", cap_d[1], 32'hFFFFA5A4);
      check("split_c1", cap_c[1], 2);
    end

    // Backpressure: input noise while held is ignored.
    push(8'h5A, 0);
    push(8'h6B, 0);
    push(8'h7C, 0);
    push(8'h8D, 0);
    saved = 32'h8D7C6B5A;
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'($urandom);
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("bp_data", bus1.m_data, saved);
    check("bp_count", bus1.m_count, 4);
    check("bp_valid", bus1.m_valid, 1);
    handshake();

    // Reset mid-frame, then a clean frame.
    push(8'hAA, 0);
    push(8'hBB, 0);
    rst = 1'b1;
    #1;
    check("rst_mid_sready", bus1.s_ready, 0);
    step();
    rst = 1'b0;
    check("rst_mid_valid", bus1.m_valid, 0);
    push(8'h10, 0);
    push(8'h20, 0);
    push(8'h30, 0);
    push(8'h40, 0);
    check("post_rst_data", bus1.m_data, 32'h40302010);
    check("post_rst_count", bus1.m_count, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_hold_valid", bus1.m_valid, 0);
    check("rst_hold_data", bus1.m_data, 32'hFFFFFFFF);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = 8'($urandom);
      s_last  = ($urandom_range(0, 4) == 0);
      m_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    rst = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/brick_sort_frame_packer.md
# brick_sort_frame_packer

Upstream loader for the brick (odd-even transposition) sort network. Collects a serial stream of DATA_WIDTH elements into one frame of INPUT_NUM = 2**LOG_INPUT_NUM lanes and presents the frame as a flat, registered vector on the network's parallel input. Short frames are padded with a value that sorts to the tail, so padding collects in the top lanes of the sorted output. A valid/ready handshake runs on both sides. The block holds one frame at a time.

## Interface
- LOG_INPUT_NUM, 4, log2 of lanes per frame; INPUT_NUM = 2**LOG_INPUT_NUM (derived, not overridable)
- DATA_WIDTH, 8, element width in bits, unsigned
- ASCENDING, 1, 1: pad value PAD = all-ones; 0: PAD = all-zeros
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- s_data  in  DATA_WIDTH  input element
- s_valid  in  1  s_data valid
- s_last  in  1  element is the final one of its frame; meaningful only when s_valid=1
- s_ready  out  1  block accepts s_data this cycle
- m_data  out  INPUT_NUM*DATA_WIDTH  frame; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- m_count  out  LOG_INPUT_NUM+1  number of real (non-pad) lanes, range 1..INPUT_NUM
- m_valid  out  1  frame complete and held
- m_ready  in  1  sort network / consumer takes the frame

## Operation
- Two states: FILL and HOLD. Write index idx has width LOG_INPUT_NUM. Lane registers are lane[0..INPUT_NUM-1].
- s_ready = (state==FILL) && !rst. Combinational, no dependence on m_ready.
- An element is accepted when s_valid && s_ready. On acceptance, lane[idx] <= s_data.
- In FILL, on acceptance:
  - If s_last=1 or idx==INPUT_NUM-1: m_count <= idx+1, m_valid <= 1, state <= HOLD, idx <= 0.
  - Otherwise: idx <= idx+1.
- A frame with more than INPUT_NUM elements is split. The frame closes after lane INPUT_NUM-1. The next element starts a new frame. No error flag.
- An s_last that arrives exactly on the INPUT_NUM-th element closes only that one frame.
- Lanes not written in a frame keep PAD. All lanes are preset to PAD at reset and on every output handshake.
- In HOLD: m_data, m_count and m_valid stay stable. s_data, s_valid and s_last are ignored.
- In HOLD with m_ready=1 (handshake):
  - m_valid <= 0
  - all lanes <= PAD
  - m_count <= 0
  - state <= FILL
- m_ready while in FILL has no effect.
- m_data is driven directly from the lane registers. It is defined only while m_valid=1; in FILL it shows the partial frame.
- Reset (any cycle, including mid-frame or in HOLD) gives: state=FILL, idx=0, m_valid=0, m_count=0, all lanes=PAD, s_ready=0 during the reset cycle. Any partial or held frame is discarded.

## Timing
- Latency: last element accepted at edge k → m_valid=1 from cycle k+1. Element data appears in its lane in the same cycle k+1.
- Output handshake at edge h → m_valid=0 and s_ready=1 in cycle h+1. The first element of the next frame can be accepted at edge h+1.
- Throughput for full frames with continuous valid and ready: INPUT_NUM accept cycles plus 1 HOLD cycle per frame.
- No combinational path from m_ready to s_ready, or from s_valid to m_valid.
- Every output is registered, except s_ready, which is decoded from state and rst.

## Test plan
- Full frame (LOG_INPUT_NUM=2, DATA_WIDTH=8, ASCENDING=1): send 0x11, 0x22, 0x33, 0x44 with no s_last and m_ready=0 → m_valid rises the cycle after 0x44. m_data=0x44332211, m_count=4, s_ready=0 until m_ready is pulsed.
- Short frame: send 0x05, 0x09 with s_last on 0x09 → m_data=0xFFFF0905, m_count=2. Repeat with ASCENDING=0 → m_data=0x00000905.
- Single element with s_last → m_count=1, m_data=0xFFFFFF07 for s_data=0x07. Handshake, then a new 3-element frame 0x01, 0x02, 0x03 with last → m_data=0xFF030201, m_count=3: no stale lanes from the previous frame.
- Over-long frame: 6 elements 0xA0..0xA5, s_last on 0xA5 → frame 1 = 0xA3A2A1A0 with count 4, then frame 2 = 0xFFFFA5A4 with count 2. s_valid held high throughout; check that s_ready drops for exactly 1 cycle between the frames when m_ready=1.
- Backpressure and HOLD stability: hold m_ready=0 for 10 cycles while toggling s_valid, s_data and s_last → m_data, m_count and m_valid do not change, and no element is accepted.
- Reset mid-frame: accept 2 elements, assert rst for 1 cycle → m_valid=0 and s_ready=0 during reset. Next frame 0x10, 0x20, 0x30, 0x40 → m_data=0x40302010, m_count=4, with no trace of the pre-reset elements. Also assert rst during HOLD → m_valid=0 the next cycle.
